ring_bridge_scheduler: RTL and testbench

Round-robin scheduler that shares the inter-bus UART ring between the three bus-system nodes. Only one node at a time may launch a cross-bus transfer over its bridge UART. Each node raises a request and receives an exclusive grant until it signals completion. The block sits in the combined top level beside the three node instances, drives a per-node grant, and reports the current owner for display and debug.

---
 rtl/ring_bridge_scheduler_pkg.sv | 20 ++
 rtl/ring_bridge_scheduler_if.sv | 23 ++
 rtl/ring_bridge_scheduler_rr_pick3.sv | 29 ++
 rtl/ring_bridge_scheduler.sv | 112 +++++++++++
 tb/tb_ring_bridge_scheduler.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/ring_bridge_scheduler_pkg.sv
// Shared encodings and sizes for the inter-bus UART ring scheduler.
// Imported by the scheduler top, its interface and the rr_pick3 encoder.
package ring_bridge_scheduler_pkg;

  localparam int N_NODES                = 3;
  localparam int ID_W                   = 2;
  localparam int TIMEOUT_CYCLES_DEFAULT = 4096;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } sched_state_t;

  // Next node index in ring order 0 -> 1 -> 2 -> 0; any out-of-range id restarts at 0.
  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id >= ID_W'(N_NODES - 1)) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/ring_bridge_scheduler_if.sv
// Request/grant bundle between the three bus nodes and the ring scheduler.
// master = node side (drives req/done), slave = scheduler side (drives grant/status).
interface ring_bridge_scheduler_if;
  import ring_bridge_scheduler_pkg::*;

  logic [N_NODES-1:0] req;
  logic [N_NODES-1:0] done;
  logic [N_NODES-1:0] grant;
  logic               busy;
  logic [ID_W-1:0]    owner_id;
  logic               timeout_pulse;

  modport master (
    output req, done,
    input  grant, busy, owner_id, timeout_pulse
  );

  modport slave (
    input  req, done,
    output grant, busy, owner_id, timeout_pulse
  );

endinterface

// File: rtl/ring_bridge_scheduler_rr_pick3.sv
// rr_pick3: combinational rotating-priority encoder for three requesters.
// The search starts one past last_id, so the previous winner is considered last.
module rr_pick3
  import ring_bridge_scheduler_pkg::*;
(
  input  logic [N_NODES-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic               valid,
  output logic [ID_W-1:0]    id,
  output logic [N_NODES-1:0] onehot
);

  logic [ID_W-1:0] cand0, cand1, cand2;

  always_comb begin
    // NOTE: every output gets a default before the priority chain so no path leaves it unassigned (no latch).
    valid  = |req;
    id     = '0;
    onehot = '0;
    cand0  = next_id(last_id);
    cand1  = next_id(cand0);
    cand2  = next_id(cand1);
    if (req[cand0])      id = cand0;
    else if (req[cand1]) id = cand1;
    else if (req[cand2]) id = cand2;
    if (valid) onehot = N_NODES'(1) << id;
  end

endmodule

// File: rtl/ring_bridge_scheduler.sv
// Round-robin owner of the inter-bus UART ring: IDLE -> GRANT -> RELEASE gap -> IDLE.
// Optional grant watchdog and timeout_pulse are built only when RING_SCHED_TIMEOUT_EN is defined.
module ring_bridge_scheduler
  import ring_bridge_scheduler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int TO_W           = 12
) (
  input  logic                    clock,
  input  logic                    rst,
  ring_bridge_scheduler_if.slave  bus
);

  if ((2 ** TO_W) < TIMEOUT_CYCLES) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT_CYCLES");
  end

  sched_state_t       state;
  logic [N_NODES-1:0] grant_q;
  logic               busy_q;
  logic [ID_W-1:0]    owner_q;

  logic               pick_valid;
  logic [ID_W-1:0]    pick_id;
  logic [N_NODES-1:0] pick_onehot;

  rr_pick3 u_pick (
    .req    (bus.req),
    .last_id(owner_q),
    .valid  (pick_valid),
    .id     (pick_id),
    .onehot (pick_onehot)
  );

  // The grant register is one-hot on the owner, so masking with it selects the owner's inputs.
  logic owner_done, owner_req;
  assign owner_done = |(bus.done & grant_q);
  assign owner_req  = |(bus.req  & grant_q);

`ifdef RING_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] count_q;
  logic            timeout_q;
  logic            wd_hit;
  assign wd_hit = (count_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  logic            wd_hit;
  assign wd_hit = 1'b0;
`endif

  // NOTE: state and outputs are flops updated with non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      owner_q <= ID_W'(N_NODES - 1);
`ifdef RING_SCHED_TIMEOUT_EN
      count_q   <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef RING_SCHED_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state   <= ST_GRANT;
            grant_q <= pick_onehot;
            owner_q <= pick_id;
            busy_q  <= 1'b1;
`ifdef RING_SCHED_TIMEOUT_EN
            count_q <= '0;
`endif
          end
        end
        ST_GRANT: begin
`ifdef RING_SCHED_TIMEOUT_EN
          count_q <= count_q + 1'b1;
`endif
          if (owner_done || !owner_req || wd_hit) begin
            state   <= ST_RELEASE;
            grant_q <= '0;
`ifdef RING_SCHED_TIMEOUT_EN
            // A watchdog expiry that coincides with a normal release is not a forced release.
            timeout_q <= wd_hit && !owner_done && owner_req;
`endif
          end
        end
        ST_RELEASE: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.busy     = busy_q;
  assign bus.owner_id = owner_q;
`ifdef RING_SCHED_TIMEOUT_EN
  assign bus.timeout_pulse = timeout_q;
`else
  assign bus.timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_ring_bridge_scheduler.sv
// Directed bench for ring_bridge_scheduler with a 16-cycle watchdog; expectations
// follow whichever build of RING_SCHED_TIMEOUT_EN is compiled.
module tb_ring_bridge_scheduler;
  import ring_bridge_scheduler_pkg::*;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  ring_bridge_scheduler_if bus ();

  ring_bridge_scheduler #(
    .TIMEOUT_CYCLES(16),
    .TO_W          (4)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later, clear of the active edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [1:0] exp_id [4];
    logic [2:0] exp_oh;
    logic       pulse_seen;
    exp_id = '{2'd0, 2'd1, 2'd2, 2'd0};

    bus.req  = '0;
    bus.done = '0;
    #12;
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_owner", 32'(bus.owner_id), 2);
    check("rst_tp", 32'(bus.timeout_pulse), 0);
    rst = 1'b0;

    // First grant latency, then release by the owner dropping req.
    step();
    bus.req = 3'b001;
    #1 check("lat_no_comb", 32'(bus.grant), 0);
    step();
    check("lat_grant", 32'(bus.grant), 32'h1);
    check("lat_owner", 32'(bus.owner_id), 0);
    check("lat_busy", 32'(bus.busy), 1);
    bus.req = 3'b000;
    step();
    check("drop_rel_grant", 32'(bus.grant), 0);
    check("drop_rel_busy", 32'(bus.busy), 1);
    step();
    check("drop_idle_busy", 32'(bus.busy), 0);

    // Rotation with all three requesting; done 5 cycles after each grant.
    #2 rst = 1'b1;
    @(posedge clock);
    #3 rst = 1'b0;
    bus.req = 3'b111;
    step();
    for (int i = 0; i < 4; i++) begin
      exp_oh = 3'b001 << exp_id[i];
      check("rot_grant", 32'(bus.grant), 32'(exp_oh));
      check("rot_owner", 32'(bus.owner_id), 32'(exp_id[i]));
      repeat (4) step();
      bus.done = exp_oh;
      step();
      bus.done = '0;
      check("rot_rel_grant", 32'(bus.grant), 0);
      check("rot_rel_busy", 32'(bus.busy), 1);
      step();
      check("rot_idle_grant", 32'(bus.grant), 0);
      check("rot_idle_busy", 32'(bus.busy), 0);
      if (i < 3) step();
    end
    bus.req = '0;
    step();

    // Watchdog on node 1 holding req without done.
    #2 rst = 1'b1;
    @(posedge clock);
    #3 rst = 1'b0;
    bus.req = 3'b010;
    step();
    check("wd_grant", 32'(bus.grant), 32'h2);
`ifdef RING_SCHED_TIMEOUT_EN
    repeat (15) step();
    check("wd_hold15", 32'(bus.grant), 32'h2);
    check("wd_tp_early", 32'(bus.timeout_pulse), 0);
    step();
    check("wd_rel_grant", 32'(bus.grant), 0);
    check("wd_tp", 32'(bus.timeout_pulse), 1);
    check("wd_owner", 32'(bus.owner_id), 1);
    check("wd_rel_busy", 32'(bus.busy), 1);
    bus.req = '0;
    step();
    check("wd_tp_clear", 32'(bus.timeout_pulse), 0);
    step();
`else
    pulse_seen = 1'b0;
    repeat (40) begin
      step();
      pulse_seen = pulse_seen | bus.timeout_pulse;
    end
    check("nowd_hold", 32'(bus.grant), 32'h2);
    check("nowd_tp", 32'(pulse_seen), 0);
    bus.req = '0;
    step();
    check("nowd_rel_grant", 32'(bus.grant), 0);
    step();
    step();
`endif
    check("wd_idle_busy", 32'(bus.busy), 0);

    // Non-owner noise is ignored; done coinciding with watchdog expiry is a normal release.
    bus.req = 3'b001;
    step();
    check("noise_grant", 32'(bus.grant), 32'h1);
    bus.req  = 3'b101;
    bus.done = 3'b100;
    step();
    bus.done = '0;
    bus.req  = 3'b001;
    check("noise_hold", 32'(bus.grant), 32'h1);
    repeat (14) step();
    check("coin_hold", 32'(bus.grant), 32'h1);
    bus.done = 3'b001;
    step();
    bus.done = '0;
    bus.req  = '0;
    check("coin_rel_grant", 32'(bus.grant), 0);
    check("coin_tp", 32'(bus.timeout_pulse), 0);
    check("coin_busy", 32'(bus.busy), 1);
    step();
    check("coin_idle_busy", 32'(bus.busy), 0);

    // Asynchronous reset in the middle of a grant.
    bus.req = 3'b110;
    step();
    check("mid_grant", 32'(bus.grant), 32'h2);
    step();
    #3 rst = 1'b1;
    #1;
    check("mid_rst_grant", 32'(bus.grant), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_owner", 32'(bus.owner_id), 2);
    @(posedge clock);
    #3 rst = 1'b0;
    step();
    check("post_rst_grant", 32'(bus.grant), 32'h2);
    check("post_rst_owner", 32'(bus.owner_id), 1);

    // Owner drops req; the other requester follows three edges later.
    bus.req = 3'b100;
    step();
    check("hand_rel_grant", 32'(bus.grant), 0);
    check("hand_rel_busy", 32'(bus.busy), 1);
    step();
    check("hand_idle_grant", 32'(bus.grant), 0);
    step();
    check("hand_next_grant", 32'(bus.grant), 32'h4);
    check("hand_next_owner", 32'(bus.owner_id), 2);
    bus.req = '0;
    repeat (3) step();
    check("end_busy", 32'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
